// File: rtl/noise_pkg.sv
// rtl/noise_pkg.sv - shared constants and arbiter state encoding for the noise tap scheduler
package noise_pkg;
    localparam int NUM_REQ_MAX = 16;
    localparam int DATA_W      = 16;
    localparam int RATE_W      = 16;

    typedef enum logic {
        IDLE = 1'b0,
        ARB  = 1'b1
    } state_t;
endpackage

// File: rtl/noise_tap_scheduler_rr_pick.sv
// rtl/noise_tap_scheduler_rr_pick.sv - combinational round-robin selector over the pending vector
module rr_pick #(
    parameter int NUM_REQ = 8,
    parameter int LAST_W  = 3
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [LAST_W-1:0]  last,
    output logic [NUM_REQ-1:0] sel,
    output logic               any_pending
);
    // Scan starts just after the previous winner and wraps, so the last winner ranks lowest.
    always_comb begin
        int idx;
        logic found;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && pending[idx]) begin
                sel[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any_pending = |pending;
endmodule

// File: rtl/noise_tap_scheduler.sv
// rtl/noise_tap_scheduler.sv - paces the shared LFSR and hands each step's noise word to one voice
module noise_tap_scheduler #(
    parameter int NUM_REQ = 8,
    parameter int DATA_W  = noise_pkg::DATA_W,
    parameter int RATE_W  = noise_pkg::RATE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [RATE_W-1:0]  rate_div,
    input  logic [DATA_W-1:0]  noise_in,
    input  logic [NUM_REQ-1:0] req,
    output logic               step_en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [DATA_W-1:0]  noise_out,
    output logic               noise_valid,
    output logic [NUM_REQ-1:0] pending
);
    import noise_pkg::*;

    localparam int LAST_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [RATE_W-1:0]  cnt;
    logic [LAST_W-1:0]  last;
    logic [LAST_W-1:0]  sel_idx;
    logic [NUM_REQ-1:0] sel;
    logic [NUM_REQ-1:0] clr;
    logic [NUM_REQ-1:0] pending_next;
    logic               any_pending;
    logic               do_grant;
    state_t             state;
    state_t             state_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .LAST_W  (LAST_W)
    ) u_rr_pick (
        .pending     (pending),
        .last        (last),
        .sel         (sel),
        .any_pending (any_pending)
    );

    // The >= compare lets a shrunken rate_div fire immediately instead of wrapping the counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            step_en <= 1'b0;
        end else if (run) begin
            if (cnt >= rate_div) begin
                cnt     <= '0;
                step_en <= 1'b1;
            end else begin
                cnt     <= cnt + 1'b1;
                step_en <= 1'b0;
            end
        end else begin
            step_en <= 1'b0;
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel[i]) sel_idx = LAST_W'(i);
        end
    end

    // A new request on the granted index wins over the clear, so back-to-back requests are not lost.
    always_comb begin
        do_grant     = step_en && run && (state == ARB) && any_pending;
        clr          = do_grant ? sel : '0;
        pending_next = (pending & ~clr) | req;
        state_next   = state;
        case (state)
            IDLE:    if (|pending_next)  state_next = ARB;
            ARB:     if (!(|pending_next)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= '0;
            last        <= LAST_W'(NUM_REQ - 1);
            gnt         <= '0;
            noise_out   <= '0;
            noise_valid <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            if (do_grant) begin
                gnt         <= sel;
                noise_out   <= noise_in;
                noise_valid <= 1'b1;
                last        <= sel_idx;
            end else begin
                gnt         <= '0;
                noise_valid <= 1'b0;
            end
        end
    end
endmodule
